// File: rtl/rf_writeback_queue.sv
// Register-file writeback queue: two in-order enqueue channels, drains up to two
// entries per cycle onto two write ports, merging back-to-back writes to one register.
module rf_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [3:0]               a_addr,
  input  logic [15:0]              a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [3:0]               b_addr,
  input  logic [15:0]              b_data,
  input  logic                     stall,
  output logic [1:0]               wr_en,
  output logic [3:0]               wr_addr1,
  output logic [3:0]               wr_addr2,
  output logic [15:0]              wr_data1,
  output logic [15:0]              wr_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_M2 = CW'(DEPTH - 2);

  logic [3:0]    addr_mem [DEPTH];
  logic [15:0]   data_mem [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] next_ptr, b_slot;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    pop_cnt;
  logic          push_a, push_b;

  logic [1:0]    wr_en_q, wr_en_d;
  logic [3:0]    wr_addr1_q, wr_addr1_d, wr_addr2_q, wr_addr2_d;
  logic [15:0]   wr_data1_q, wr_data1_d, wr_data2_q, wr_data2_d;

  // Readiness looks only at the registered occupancy so it never depends on a same-cycle drain
  assign a_ready = rst && (count_q <= DEPTH_M1);
  assign b_ready = rst && (count_q <= DEPTH_M2);
  assign push_a  = a_valid && a_ready;
  assign push_b  = b_valid && b_ready;
  assign next_ptr = rd_ptr_q + 1'b1;
  assign b_slot   = push_a ? wr_ptr_q + 1'b1 : wr_ptr_q;

  always_comb begin
    pop_cnt    = 2'd0;
    wr_en_d    = 2'b00;
    wr_addr1_d = '0;
    wr_addr2_d = '0;
    wr_data1_d = '0;
    wr_data2_d = '0;
    if (!stall) begin
      if (count_q == CW'(1)) begin
        pop_cnt    = 2'd1;
        wr_en_d    = 2'b01;
        wr_addr1_d = addr_mem[rd_ptr_q];
        wr_data1_d = data_mem[rd_ptr_q];
      end else if (count_q >= CW'(2)) begin
        pop_cnt = 2'd2;
        // Same register twice: only the younger value survives, the older write is dropped
        if (addr_mem[rd_ptr_q] == addr_mem[next_ptr]) begin
          wr_en_d    = 2'b01;
          wr_addr1_d = addr_mem[next_ptr];
          wr_data1_d = data_mem[next_ptr];
        end else begin
          wr_en_d    = 2'b11;
          wr_addr1_d = addr_mem[rd_ptr_q];
          wr_data1_d = data_mem[rd_ptr_q];
          wr_addr2_d = addr_mem[next_ptr];
          wr_data2_d = data_mem[next_ptr];
        end
      end
    end
    rd_ptr_d = rd_ptr_q + AW'(pop_cnt);
    wr_ptr_d = wr_ptr_q + AW'(push_a) + AW'(push_b);
    count_d  = count_q + CW'(push_a) + CW'(push_b) - CW'(pop_cnt);
  end

  always_ff @(posedge clk) begin
    if (push_a) begin
      addr_mem[wr_ptr_q] <= a_addr;
      data_mem[wr_ptr_q] <= a_data;
    end
    if (push_b) begin
      addr_mem[b_slot] <= b_addr;
      data_mem[b_slot] <= b_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wr_en_q    <= 2'b00;
      wr_addr1_q <= '0;
      wr_addr2_q <= '0;
      wr_data1_q <= '0;
      wr_data2_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      wr_addr1_q <= wr_addr1_d;
      wr_addr2_q <= wr_addr2_d;
      wr_data1_q <= wr_data1_d;
      wr_data2_q <= wr_data2_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr1 = wr_addr1_q;
  assign wr_addr2 = wr_addr2_q;
  assign wr_data1 = wr_data1_q;
  assign wr_data2 = wr_data2_q;
  assign count    = count_q;

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Bench for rf_writeback_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the drain/merge rules.
module tb_rf_writeback_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } entry_t;

  logic        clk;
  logic        rst;
  logic        a_valid, b_valid, stall;
  logic        a_ready, b_ready;
  logic [3:0]  a_addr, b_addr;
  logic [15:0] a_data, b_data;
  logic [1:0]  wr_en;
  logic [3:0]  wr_addr1, wr_addr2;
  logic [15:0] wr_data1, wr_data2;
  logic [$clog2(DEPTH):0] count;

  int compared;
  int mismatched;

  entry_t      modelQ[$];
  logic [1:0]  expEn;
  logic [3:0]  expA1, expA2;
  logic [15:0] expD1, expD2;

  rf_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .stall(stall),
    .wr_en(wr_en), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2),
    .wr_data1(wr_data1), .wr_data2(wr_data2),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkAllOutputs(input string tag);
    checkOutput({tag, "_wr_en"}, 32'(wr_en), 32'(expEn));
    checkOutput({tag, "_addr1"}, 32'(wr_addr1), 32'(expA1));
    checkOutput({tag, "_data1"}, 32'(wr_data1), 32'(expD1));
    checkOutput({tag, "_addr2"}, 32'(wr_addr2), 32'(expA2));
    checkOutput({tag, "_data2"}, 32'(wr_data2), 32'(expD2));
    checkOutput({tag, "_count"}, 32'(count), 32'(modelQ.size()));
  endtask

  // One clock: drive at the falling edge, check readiness, advance the model, check outputs after the edge
  task automatic applyStimulus(input string tag,
                               input logic av, input logic [3:0] aa, input logic [15:0] ad,
                               input logic bv, input logic [3:0] ba, input logic [15:0] bd,
                               input logic st);
    entry_t h, n;
    bit     aRdy, bRdy;
    int     sz;
    @(negedge clk);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    stall   = st;
    #1;
    sz   = modelQ.size();
    aRdy = (sz <= DEPTH - 1);
    bRdy = (sz <= DEPTH - 2);
    checkOutput({tag, "_a_ready"}, 32'(a_ready), 32'(aRdy));
    checkOutput({tag, "_b_ready"}, 32'(b_ready), 32'(bRdy));
    expEn = 2'b00; expA1 = '0; expA2 = '0; expD1 = '0; expD2 = '0;
    if (!st && sz == 1) begin
      h = modelQ.pop_front();
      expEn = 2'b01; expA1 = h.addr; expD1 = h.data;
    end else if (!st && sz >= 2) begin
      h = modelQ.pop_front();
      n = modelQ.pop_front();
      if (h.addr == n.addr) begin
        expEn = 2'b01; expA1 = n.addr; expD1 = n.data;
      end else begin
        expEn = 2'b11; expA1 = h.addr; expD1 = h.data; expA2 = n.addr; expD2 = n.data;
      end
    end
    if (av && aRdy) modelQ.push_back('{aa, ad});
    if (bv && bRdy) modelQ.push_back('{ba, bd});
    @(posedge clk);
    #1;
    checkAllOutputs(tag);
  endtask

  task automatic idle(input string tag, input logic st);
    applyStimulus(tag, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, st);
  endtask

  // Asynchronous reset mid-cycle: the queue must empty and outputs clear without waiting for an edge
  task automatic pulseReset(input string tag);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    modelQ.delete();
    expEn = 2'b00; expA1 = '0; expA2 = '0; expD1 = '0; expD2 = '0;
    checkAllOutputs(tag);
    checkOutput({tag, "_a_ready_rst"}, 32'(a_ready), 32'd0);
    checkOutput({tag, "_b_ready_rst"}, 32'(b_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; stall = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    expEn = 2'b00; expA1 = '0; expA2 = '0; expD1 = '0; expD2 = '0;

    pulseReset("init");

    // Single push into an empty queue
    applyStimulus("single_push", 1'b1, 4'hA, 16'hFFFF, 1'b0, 4'h0, 16'h0, 1'b0);
    idle("single_drain", 1'b0);
    checkOutput("single_const_en", 32'(wr_en), 32'h1);
    checkOutput("single_const_a1", 32'(wr_addr1), 32'hA);
    checkOutput("single_const_d1", 32'(wr_data1), 32'hFFFF);
    checkOutput("single_const_cnt", 32'(count), 32'h0);

    // Dual push, distinct addresses
    applyStimulus("dual_push", 1'b1, 4'hB, 16'hFFFF, 1'b1, 4'h0, 16'hABCD, 1'b0);
    idle("dual_drain", 1'b0);
    checkOutput("dual_const_en", 32'(wr_en), 32'h3);
    checkOutput("dual_const_d2", 32'(wr_data2), 32'hABCD);

    // Same-address pair merges into one write carrying the younger data
    applyStimulus("merge_push", 1'b1, 4'h5, 16'h1111, 1'b1, 4'h5, 16'h2222, 1'b0);
    idle("merge_drain", 1'b0);
    checkOutput("merge_const_en", 32'(wr_en), 32'h1);
    checkOutput("merge_const_d1", 32'(wr_data1), 32'h2222);
    idle("merge_after", 1'b0);

    // Fill under stall, third request refused, then drain in order
    applyStimulus("stall_fill1", 1'b1, 4'h1, 16'h0101, 1'b1, 4'h2, 16'h0202, 1'b1);
    applyStimulus("stall_fill2", 1'b1, 4'h3, 16'h0303, 1'b1, 4'h4, 16'h0404, 1'b1);
    applyStimulus("stall_full", 1'b1, 4'h7, 16'h7777, 1'b1, 4'h8, 16'h8888, 1'b1);
    checkOutput("stall_full_cnt", 32'(count), 32'd4);
    idle("stall_rel1", 1'b0);
    idle("stall_rel2", 1'b0);
    checkOutput("stall_rel2_a1", 32'(wr_addr1), 32'h3);
    idle("stall_rel3", 1'b0);

    // At three entries only channel A may enter
    applyStimulus("three_fill1", 1'b1, 4'h1, 16'h1001, 1'b1, 4'h2, 16'h1002, 1'b1);
    applyStimulus("three_fill2", 1'b1, 4'h3, 16'h1003, 1'b0, 4'h0, 16'h0, 1'b1);
    applyStimulus("three_both", 1'b1, 4'h4, 16'h1004, 1'b1, 4'h5, 16'h1005, 1'b1);
    checkOutput("three_cnt", 32'(count), 32'd4);
    idle("three_drain1", 1'b0);
    idle("three_drain2", 1'b0);
    idle("three_drain3", 1'b0);

    // Reset with entries pending: nothing stale may emerge afterwards
    applyStimulus("rst_fill1", 1'b1, 4'h9, 16'h9999, 1'b1, 4'hC, 16'hCCCC, 1'b1);
    applyStimulus("rst_fill2", 1'b1, 4'hD, 16'hDDDD, 1'b0, 4'h0, 16'h0, 1'b1);
    pulseReset("midrst");
    idle("post_rst1", 1'b0);
    idle("post_rst2", 1'b0);

    // Random traffic with a narrow address range to exercise merging
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom),
                    1'($urandom_range(0, 9) < 3));
      if (i == 200) pulseReset("rand_rst");
    end
    for (int i = 0; i < 3; i++) idle("final_drain", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
